// File: rtl/date_display_pkg.sv
// Shared constants and the default date table for the date display controller.
// Digit 0 is the rightmost display digit; each date holds NUM_DIGITS BCD codes.
package date_display_pkg;

    localparam logic [3:0] BLANK_CODE = 4'hF;
    localparam logic [7:0] SEG_BLANK  = 8'hFF;

    localparam int DEF_NUM_DIGITS = 6;
    localparam int DEF_NUM_DATES  = 4;

    // Dates read left to right: 120524, 010125, __3112, 290228 (date 3 first).
    localparam logic [DEF_NUM_DATES*DEF_NUM_DIGITS*4-1:0] DEF_DATE_TABLE =
        96'h290228_FF3112_010125_120524;

    typedef enum logic {
        MANUAL = 1'b0,
        AUTO   = 1'b1
    } mode_e;

endpackage

// File: rtl/date_display_key_debounce.sv
// Active-low push-button conditioner: 2-flop synchroniser, level debouncer and a
// registered one-cycle press pulse on the accepted released->pressed transition.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_i,
    output logic press_o
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [1:0]       sync_q;
    logic             stable_q, stable_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Any sample matching the accepted level restarts the count.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        press_d  = 1'b0;
        if (sync_q[1] != stable_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = sync_q[1];
                press_d  = stable_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q   <= 2'b11;
            stable_q <= 1'b1;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync_q   <= {sync_q[0], key_i};
            stable_q <= stable_d;
            press_q  <= press_d;
            cnt_q    <= cnt_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/sevenSeg.sv
// BCD to seven-segment decoder, active-low, bit 0 = segment a .. bit 6 = segment g.
// Codes outside 0-9 decode to all segments off.
module sevenSeg (
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = 7'h7F;
        case (bcd_i)
            4'd0: seg_o = 7'h40;
            4'd1: seg_o = 7'h79;
            4'd2: seg_o = 7'h24;
            4'd3: seg_o = 7'h30;
            4'd4: seg_o = 7'h19;
            4'd5: seg_o = 7'h12;
            4'd6: seg_o = 7'h02;
            4'd7: seg_o = 7'h78;
            4'd8: seg_o = 7'h00;
            4'd9: seg_o = 7'h10;
            default: seg_o = 7'h7F;
        endcase
    end

endmodule

// File: rtl/date_display_ctrl.sv
// Date display controller: switch-to-LED mirror with key0 invert toggle, and a
// date selector stepped by key1 or, in auto mode, by a dwell timer.
module date_display_ctrl
    import date_display_pkg::*;
#(
    parameter int NUM_DIGITS      = DEF_NUM_DIGITS,
    parameter int NUM_DATES       = DEF_NUM_DATES,
    parameter logic [NUM_DATES*NUM_DIGITS*4-1:0] DATE_TABLE = DEF_DATE_TABLE,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int DWELL_CYCLES    = 100_000_000,
    parameter int NUM_SW          = 10
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_SW-1:0]       switch,
    input  logic [1:0]              key,
    output logic [NUM_SW-1:0]       leds,
    output logic [NUM_DIGITS*8-1:0] hex
);

    localparam int IDX_W   = (NUM_DATES > 1)    ? $clog2(NUM_DATES)    : 1;
    localparam int DWELL_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

    logic [1:0]         press;
    logic [1:0]         auto_sync_q;
    mode_e              state_q, state_d;
    logic               invert_q, invert_d;
    logic [NUM_SW-1:0]  leds_q, leds_d;
    logic [IDX_W-1:0]   date_idx_q, date_idx_d, date_idx_inc;
    logic [DWELL_W-1:0] dwell_q, dwell_d;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key [1:0] (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .key_i  (key),
        .press_o(press)
    );

    // With a single date the wrap compare is always true, pinning the index at 0.
    assign date_idx_inc = (date_idx_q == IDX_W'(NUM_DATES - 1)) ? '0 : date_idx_q + 1'b1;

    always_comb begin
        state_d    = mode_e'(auto_sync_q[1]);
        dwell_d    = '0;
        date_idx_d = date_idx_q;
        invert_d   = invert_q ^ press[0];
        leds_d     = invert_q ? ~switch : switch;
        case (state_q)
            AUTO: begin
                // A press on the expiry cycle still advances only once.
                if (press[1] || dwell_q == DWELL_W'(DWELL_CYCLES - 1)) begin
                    date_idx_d = date_idx_inc;
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            default: begin
                if (press[1]) date_idx_d = date_idx_inc;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            auto_sync_q <= 2'b00;
            state_q     <= MANUAL;
            invert_q    <= 1'b0;
            leds_q      <= '0;
            date_idx_q  <= '0;
            dwell_q     <= '0;
        end else begin
            auto_sync_q <= {auto_sync_q[0], switch[NUM_SW-1]};
            state_q     <= state_d;
            invert_q    <= invert_d;
            leds_q      <= leds_d;
            date_idx_q  <= date_idx_d;
            dwell_q     <= dwell_d;
        end
    end

    assign leds = leds_q;

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
        logic [3:0] code;
        logic [6:0] seg;
        assign code = DATE_TABLE[(int'(date_idx_q) * NUM_DIGITS + k) * 4 +: 4];
        sevenSeg u_seg (
            .bcd_i(code),
            .seg_o(seg)
        );
        assign hex[k*8 +: 8] = (code == BLANK_CODE) ? SEG_BLANK : {1'b1, seg};
    end

endmodule

// File: tb/tb_date_display_ctrl.sv
// Self-checking bench for date_display_ctrl with short debounce/dwell timing.
module tb_date_display_ctrl;

    localparam int NSW = 10;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [NSW-1:0]   switch;
    logic [1:0]       key;
    logic [NSW-1:0]   leds;
    logic [47:0]      hex;

    date_display_ctrl #(
        .NUM_DIGITS(6), .NUM_DATES(4), .DEBOUNCE_CYCLES(4),
        .DWELL_CYCLES(10), .NUM_SW(NSW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .switch(switch),
        .key(key), .leds(leds), .hex(hex)
    );

    always #5 clk = ~clk;

    // Expected segment images of the four default dates (digit 5 leftmost).
    logic [47:0] date_hex [4] = '{48'hF9A4C092A499, 48'hC0F9C0F9A492,
                                  48'hFFFFB0F9F9A4, 48'hA490C0A4A480};

    typedef struct { string name; logic [63:0] exp; } sb_t;
    sb_t sbq[$];
    int  checks = 0;
    int  errors = 0;
    int  edges  = 0;
    int  lat    = 0;

    typedef struct { logic [NSW-1:0] sw; logic inv; logic [NSW-1:0] leds; } vec_t;
    vec_t vecs [8];

    function automatic int idx_of(logic [47:0] h);
        for (int i = 0; i < 4; i++) if (h === date_hex[i]) return i;
        return -1;
    endfunction

    task automatic expect_val(string name, logic [63:0] exp);
        sb_t e;
        e.name = name;
        e.exp  = exp;
        sbq.push_back(e);
    endtask

    task automatic compare(logic [63:0] act);
        sb_t e;
        e = sbq.pop_front();
        checks++;
        if (act !== e.exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", e.name, act, e.exp);
        end
    endtask

    task automatic chk(string name, logic [63:0] exp, logic [63:0] act);
        expect_val(name, exp);
        compare(act);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edges++;
    endtask

    // Debounced key1 press; returns edges from drive to index change.
    task automatic press_key1(output int l);
        int start;
        int n;
        start = idx_of(hex);
        key[1] = 1'b0;
        n = 0;
        while (idx_of(hex) == start && n < 30) begin
            tick();
            n++;
        end
        l = n;
        repeat (20 - ((n < 20) ? n : 20)) tick();
        key[1] = 1'b1;
        repeat (10) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int l, prev, cur, base, a, nchg, first;
        int chg [$];

        vecs[0] = '{10'h0A5, 1'b0, 10'h0A5};
        vecs[1] = '{10'h1FF, 1'b0, 10'h1FF};
        vecs[2] = '{10'h000, 1'b0, 10'h000};
        vecs[3] = '{10'h155, 1'b0, 10'h155};
        vecs[4] = '{10'h0A5, 1'b1, 10'h35A};
        vecs[5] = '{10'h1FF, 1'b1, 10'h200};
        vecs[6] = '{10'h000, 1'b1, 10'h3FF};
        vecs[7] = '{10'h155, 1'b1, 10'h2AA};

        reset_n = 1'b0;
        key     = 2'b11;
        switch  = '0;
        #2;
        chk("reset_hex", date_hex[0], hex);
        chk("reset_leds", 0, leds);
        tick(); tick();
        reset_n = 1'b1;
        tick();
        chk("post_reset_hex", date_hex[0], hex);

        for (int i = 0; i < 4; i++) begin
            switch = vecs[i].sw;
            tick();
            chk("leds_plain", vecs[i].leds, leds);
        end
        switch = 10'h0A5;
        tick();
        chk("leds_0a5", 10'h0A5, leds);

        // Short glitch must be rejected, long press toggles once.
        key[0] = 1'b0;
        repeat (3) tick();
        key[0] = 1'b1;
        repeat (10) tick();
        chk("glitch_no_toggle", 10'h0A5, leds);
        key[0] = 1'b0;
        repeat (20) tick();
        chk("press_toggle", 10'h35A, leds);
        repeat (20) tick();
        chk("held_no_retoggle", 10'h35A, leds);
        key[0] = 1'b1;
        repeat (10) tick();
        chk("release_no_toggle", 10'h35A, leds);

        for (int i = 4; i < 8; i++) begin
            switch = vecs[i].sw;
            tick();
            chk("leds_inverted", vecs[i].leds, leds);
        end
        chk("hex_still_date0", date_hex[0], hex);

        for (int i = 1; i <= 4; i++) begin
            press_key1(l);
            if (i == 1) lat = l;
            chk("manual_step", i % 4, idx_of(hex));
        end
        chk("press_latency_bounded", 1, (lat > 0 && lat < 10) ? 1 : 0);

        // Auto mode for 45 cycles.
        switch = 10'h200;
        prev = idx_of(hex);
        chg.delete();
        base = edges;
        for (int n = 1; n <= 45; n++) begin
            tick();
            cur = idx_of(hex);
            if (cur != prev) begin
                chk("auto_step_plus1", (prev + 1) % 4, cur);
                chg.push_back(n);
                prev = cur;
            end
        end
        chk("auto_advances", 4, chg.size());
        if (chg.size() > 0) begin
            first = chg[0];
            chk("auto_first_advance", 1, (first >= 11 && first <= 14) ? 1 : 0);
        end
        for (int i = 1; i < chg.size(); i++)
            chk("auto_period", 10, chg[i] - chg[i-1]);
        chk("auto_wrap_to0", 0, idx_of(hex));
        switch = 10'h000;
        repeat (3) tick();
        prev = idx_of(hex);
        repeat (30) tick();
        chk("manual_frozen", prev, idx_of(hex));

        // Key1 press landing exactly on a dwell expiry.
        switch = 10'h200;
        prev = idx_of(hex);
        nchg = 0;
        while (idx_of(hex) == prev && nchg < 30) begin
            tick();
            nchg++;
        end
        chk("auto_reentry_advance", 1, (nchg < 30) ? 1 : 0);
        a = edges;
        base = idx_of(hex);
        if (lat > 0 && lat < 10) begin
            while (edges < a + 10 - lat) tick();
            key[1] = 1'b0;
            while (edges < a + 9) tick();
            chk("coincide_before", base, idx_of(hex));
            tick();
            chk("coincide_single_step", (base + 1) % 4, idx_of(hex));
            key[1] = 1'b1;
            repeat (9) tick();
            chk("coincide_hold", (base + 1) % 4, idx_of(hex));
            tick();
            chk("coincide_next_auto", (base + 2) % 4, idx_of(hex));
        end

        // Reset in the middle of a dwell with invert=1 and date 2 shown.
        switch = 10'h000;
        repeat (5) tick();
        for (int i = 0; i < 4 && idx_of(hex) != 2; i++) press_key1(l);
        chk("setup_idx2", 2, idx_of(hex));
        switch = 10'h200;
        repeat (8) tick();
        chk("setup_invert", 10'h1FF, leds);
        chk("setup_idx2_auto", 2, idx_of(hex));
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_reset_leds", 0, leds);
        chk("async_reset_hex", date_hex[0], hex);
        tick(); tick();
        reset_n = 1'b1;
        tick();
        chk("reset_clears_invert", 10'h200, leds);
        nchg = 1;
        while (idx_of(hex) == 0 && nchg < 30) begin
            tick();
            nchg++;
        end
        chk("post_reset_first_advance", 1, (nchg >= 11 && nchg <= 14) ? 1 : 0);
        chk("post_reset_step", 1, idx_of(hex));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/date_display_ctrl.md
DATE_DISPLAY_CTRL -- requirements
Module: date_display_ctrl

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameter NUM_DIGITS, default 6: number of seven-segment digits driven.
REQ-003 Parameter NUM_DATES, default 4: number of stored display patterns (dates).
REQ-004 Parameter DATE_TABLE, default from package: NUM_DATES*NUM_DIGITS 4-bit BCD codes; date d, digit k at bits [(d*NUM_DIGITS+k)*4 +: 4].
REQ-005 Parameter DEBOUNCE_CYCLES, default 1_000_000: stable cycles required to accept a key level.
REQ-006 Parameter DWELL_CYCLES, default 100_000_000: cycles each date is shown in auto mode.
REQ-007 Parameter NUM_SW, default 10: switch count; LED width equals NUM_SW.
REQ-008 clk  input  1  system clock.
REQ-009 reset_n  input  1  asynchronous active-low reset.
REQ-010 switch  input  NUM_SW  slide switches (asynchronous); switch[NUM_SW-1] selects auto mode.
REQ-011 key  input  2  push buttons, active-low (0 = pressed), asynchronous.
REQ-012 leds  output  NUM_SW  LED drive, 1 = lit.
REQ-013 hex  output  NUM_DIGITS*8  segment drive, digit k at [k*8 +: 8], active-low, bit 7 = dp.

Function
REQ-014 Each key SHALL pass through a 2-flop synchroniser, then a debouncer accepting a new level only after DEBOUNCE_CYCLES consecutive equal samples.
REQ-015 A press event SHALL be a one-cycle pulse on the debounced 1->0 transition; a held key yields exactly one event, release yields none.
REQ-016 A key0 press SHALL toggle the registered flag invert; no other event changes it.
REQ-017 leds SHALL be registered, one cycle latency: leds <= invert ? ~switch : switch.
REQ-018 Register date_idx (0..NUM_DATES-1) SHALL select the displayed date; hex is a combinational decode of date_idx and DATE_TABLE.
REQ-019 A key1 press SHALL advance date_idx by one, wrapping NUM_DATES-1 -> 0.
REQ-020 States: MANUAL (synchronised switch[NUM_SW-1]=0) and AUTO (=1); switch[NUM_SW-1] SHALL be 2-flop synchronised before use.
REQ-021 In AUTO, dwell counter counts 0..DWELL_CYCLES-1; at DWELL_CYCLES-1 date_idx advances (with wrap) and the counter returns to 0.
REQ-022 In MANUAL the dwell counter SHALL be held at 0; on MANUAL->AUTO it starts from 0 (first auto advance exactly DWELL_CYCLES cycles later).
REQ-023 A key1 press in AUTO SHALL advance date_idx and clear the dwell counter.
REQ-024 Key1 press coinciding with dwell expiry SHALL advance date_idx by exactly one.
REQ-025 Digit code 4'hF SHALL drive 8'hFF (blank); codes 0-9 SHALL drive the sevenSeg decode with dp off.
REQ-026 NUM_DATES=1 SHALL keep date_idx at 0 permanently; counter widths SHALL be $clog2-derived, minimum 1 bit.

Reset
REQ-027 On reset_n low: invert=0, date_idx=0, leds=0, dwell counter=0, synchronisers and debouncers = released (1), debounce counters=0.
REQ-028 During and directly after reset hex SHALL show date 0; no press event SHALL be generated by reset release.
REQ-029 Reset asserted mid-debounce or mid-dwell SHALL discard the partial count.

Structure
REQ-030 Package date_display_pkg SHALL hold BLANK_CODE (4'hF), SEG_BLANK (8'hFF) and the default DATE_TABLE.
REQ-031 Sub-module key_debounce (sync + debounce + press pulse, parameter DEBOUNCE_CYCLES) SHALL be instantiated once per key; digit decode SHALL reuse the existing sevenSeg decoder per digit.

Verification (DEBOUNCE_CYCLES=4, DWELL_CYCLES=10, NUM_DATES=4)
REQ-032 Reset then switch=10'h0A5 -> hex = date 0, leds=10'h0A5 one cycle later; invert=0.
REQ-033 key0 low for 3 cycles then high -> no toggle; key0 low 20 cycles -> invert=1, leds=10'h35A; held further -> no second toggle.
REQ-034 Four debounced key1 presses in MANUAL -> date_idx 1,2,3,0.
REQ-035 switch[9]=1 held 45 cycles -> date_idx advances every 10 cycles after sync (4 advances, wraps to 0); switch[9]=0 -> index frozen.
REQ-036 AUTO, key1 press event on dwell-expiry cycle -> date_idx +1 only, next auto advance 10 cycles later.
REQ-037 reset_n pulsed low mid-dwell with invert=1, date_idx=2 -> invert=0, date_idx=0, leds=0 immediately, no spurious press.
